// File: rtl/csa_pkg.sv
// csa_pkg: shared state enum, default sizes and counter-width helper for the multiword adder
package csa_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int WIDTH_D = 16;
  localparam int WORDS_D = 4;
  function automatic int cnt_w(input int words);
    return $clog2(words + 1);
  endfunction
endpackage

// File: rtl/csa_core.sv
// csa_core: conditional-sum adder, pair-sum leaves merged in doubling stages, final cin select
module csa_core #(
  parameter int WIDTH = csa_pkg::WIDTH_D
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);
  localparam int LV = $clog2(WIDTH);
  // each stage keeps both sum/carry candidates (block cin=0 and cin=1) per block of 2^k bits
  for (genvar k = 0; k <= LV; k++) begin : g
    localparam int N = WIDTH >> k;
    localparam int H = (1 << k) >> 1;
    logic [WIDTH-1:0] s0, s1;
    logic [N-1:0] c0, c1;
    if (k == 0) begin : l
      assign s0 = a ^ b;
      assign s1 = ~(a ^ b);
      assign c0 = a & b;
      assign c1 = a | b;
    end else begin : m
      for (genvar j = 0; j < N; j++) begin : p
        localparam int L = j * 2 * H;
        localparam int M = L + H;
        assign s0[L+:H] = g[k-1].s0[L+:H];
        assign s1[L+:H] = g[k-1].s1[L+:H];
        assign s0[M+:H] = g[k-1].c0[2*j] ? g[k-1].s1[M+:H] : g[k-1].s0[M+:H];
        assign s1[M+:H] = g[k-1].c1[2*j] ? g[k-1].s1[M+:H] : g[k-1].s0[M+:H];
        assign c0[j] = g[k-1].c0[2*j] ? g[k-1].c1[2*j+1] : g[k-1].c0[2*j+1];
        assign c1[j] = g[k-1].c1[2*j] ? g[k-1].c1[2*j+1] : g[k-1].c0[2*j+1];
      end
    end
  end
  assign sum = cin ? {g[LV].c1, g[LV].s1} : {g[LV].c0, g[LV].s0};
endmodule

// File: rtl/csa_multiword_seq.sv
// csa_multiword_seq: multi-precision add/sub sequencer around csa_core
// CSA_MULTIWORD_SUB_EN enables subtraction via op_sub; otherwise always adds.
module csa_multiword_seq #(
  parameter int WIDTH = csa_pkg::WIDTH_D,
  parameter int WORDS = csa_pkg::WORDS_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_last,
  output logic             carry_out,
  output logic             overflow,
  output logic             done
);
  import csa_pkg::*;
  localparam int CW = cnt_w(WORDS);
  state_t state;
  logic [CW-1:0] word_cnt;
  logic carry_q;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] b_eff;
  logic acc, last;
`ifdef CSA_MULTIWORD_SUB_EN
  logic sub_q;
  assign b_eff = sub_q ? ~b_word : b_word;
`else
  assign b_eff = b_word;
`endif
  assign busy = state != IDLE;
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign last = word_cnt == CW'(WORDS - 1);
  csa_core #(.WIDTH(WIDTH)) u_core (.a(a_word), .b(b_eff), .cin(carry_q), .sum(sum));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      carry_q   <= 1'b0;
      sum_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
`ifdef CSA_MULTIWORD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          word_cnt <= '0;
          state    <= RUN;
`ifdef CSA_MULTIWORD_SUB_EN
          carry_q  <= op_sub;
          sub_q    <= op_sub;
`else
          carry_q  <= op_sub & 1'b0;
`endif
        end
        RUN: if (acc) begin
          sum_word  <= sum[WIDTH-1:0];
          out_valid <= 1'b1;
          carry_q   <= sum[WIDTH];
          word_cnt  <= word_cnt + 1'b1;
          if (last) begin
            out_last  <= 1'b1;
            carry_out <= sum[WIDTH];
            overflow  <= (a_word[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_word[WIDTH-1]);
            state     <= DRAIN;
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
        DRAIN: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_multiword_seq.sv
// tb_csa_multiword_seq: directed checks of add/sub chaining, backpressure and reset
module tb_csa_multiword_seq;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sub = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a_word = '0, b_word = '0;
  logic busy, in_ready, out_valid, out_last, carry_out, overflow, done;
  logic [W-1:0] sum_word;
  int total = 0, bad = 0;
  logic [W-1:0] got [N];
  logic got_last [N];
  logic got_v [N];
  logic got_co, got_ov, got_done_early, got_done;
  int busy_n;

  csa_multiword_seq #(.WIDTH(W), .WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_word(a_word), .b_word(b_word),
    .out_valid(out_valid), .out_ready(out_ready), .sum_word(sum_word),
    .out_last(out_last), .carry_out(carry_out), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sub);
    @(negedge clk);
    start = 1'b1;
    op_sub = sub;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < N; i++) begin
      a_word = a[16*i+:16];
      b_word = b[16*i+:16];
      in_valid = 1'b1;
      if (busy) busy_n++;
      @(negedge clk);
      got[i] = sum_word;
      got_last[i] = out_last;
      got_v[i] = out_valid;
    end
    in_valid = 1'b0;
    got_co = carry_out;
    got_ov = overflow;
    got_done_early = done;
    if (busy) busy_n++;
    @(negedge clk);
    got_done = done;
    if (busy) busy_n++;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({busy, in_ready, out_valid, sum_word, out_last, carry_out, overflow, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b rdy=%b v=%b sum=%h last=%b co=%b ov=%b done=%b want all 0",
               busy, in_ready, out_valid, sum_word, out_last, carry_out, overflow, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [63:0] av [3];
    logic [63:0] bv [3];
    logic [63:0] ev [3];
    logic ec [3];
    logic eo [3];
    av[0] = 64'h0000_0000_0000_FFFF; bv[0] = 64'h1; ev[0] = 64'h0000_0000_0001_0000; ec[0] = 0; eo[0] = 0;
    av[1] = 64'hFFFF_FFFF_FFFF_FFFF; bv[1] = 64'h1; ev[1] = 64'h0;                   ec[1] = 1; eo[1] = 0;
    av[2] = 64'h7FFF_FFFF_FFFF_FFFF; bv[2] = 64'h1; ev[2] = 64'h8000_0000_0000_0000; ec[2] = 0; eo[2] = 1;
    for (int v = 0; v < 3; v++) begin
      do_op(av[v], bv[v], 1'b0);
      for (int i = 0; i < N; i++) begin
        total++;
        if (got[i] !== ev[v][16*i+:16] || got_v[i] !== 1'b1 || got_last[i] !== (i == N - 1)) begin
          bad++;
          $display("FAIL add%0d_word%0d got sum=%h v=%b last=%b want sum=%h v=1 last=%b",
                   v, i, got[i], got_v[i], got_last[i], ev[v][16*i+:16], i == N - 1);
        end
      end
      total++;
      if (got_co !== ec[v] || got_ov !== eo[v]) begin
        bad++;
        $display("FAIL add%0d_flags got co=%b ov=%b want co=%b ov=%b", v, got_co, got_ov, ec[v], eo[v]);
      end
      total++;
      if (got_done_early !== 1'b0 || got_done !== 1'b1 || busy_n != N + 1) begin
        bad++;
        $display("FAIL add%0d_done got early=%b done=%b busy_cycles=%0d want 0 1 %0d",
                 v, got_done_early, got_done, busy_n, N + 1);
      end
    end
  endtask

  task automatic test_sub;
    logic [63:0] e;
`ifdef CSA_MULTIWORD_SUB_EN
    e = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    e = 64'h0000_0000_0000_000C;
`endif
    do_op(64'd5, 64'd7, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (got[i] !== e[16*i+:16]) begin
        bad++;
        $display("FAIL sub_word%0d got %h want %h", i, got[i], e[16*i+:16]);
      end
    end
    total++;
    if (got_co !== 1'b0 || got_ov !== 1'b0 || got_done !== 1'b1) begin
      bad++;
      $display("FAIL sub_flags got co=%b ov=%b done=%b want 0 0 1", got_co, got_ov, got_done);
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] w [N];
    logic ok;
    w[0] = 16'h0011; w[1] = 16'h0022; w[2] = 16'h0033; w[3] = 16'h0044;
    @(negedge clk);
    start = 1'b1;
    op_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a_word = 16'h0001; b_word = 16'h0010; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (sum_word !== w[0] || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_word0 got %h v=%b want %h v=1", sum_word, out_valid, w[0]);
    end
    a_word = 16'h0002; b_word = 16'h0020;
    @(negedge clk);
    a_word = 16'h0003; b_word = 16'h0030;
    out_ready = 1'b0;
    start = 1'b1;
    #1;
    total++;
    if (sum_word !== w[1] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_word1 got %h v=%b rdy=%b want %h v=1 rdy=0", sum_word, out_valid, in_ready, w[1]);
    end
    ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (sum_word !== w[1] || out_valid !== 1'b1 || in_ready !== 1'b0 || out_last !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_hold got sum=%h v=%b rdy=%b last=%b want %h 1 0 0", sum_word, out_valid, in_ready, out_last, w[1]);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (sum_word !== w[2] || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_word2 got %h v=%b want %h v=1", sum_word, out_valid, w[2]);
    end
    a_word = 16'h0004; b_word = 16'h0040;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (sum_word !== w[3] || out_last !== 1'b1) begin
      bad++;
      $display("FAIL bp_word3 got %h last=%b want %h last=1", sum_word, out_last, w[3]);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_done got done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_word = 16'h1111; b_word = 16'h2222; in_valid = 1'b1;
    @(negedge clk);
    a_word = 16'h3333;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, in_ready, out_valid, sum_word, out_last, carry_out, overflow, done} !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs got busy=%b rdy=%b v=%b sum=%h last=%b co=%b ov=%b done=%b want all 0",
               busy, in_ready, out_valid, sum_word, out_last, carry_out, overflow, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_no_done got activity=%b want 0", seen);
    end
    do_op(64'h0004_0003_0002_FFFF, 64'h0001_0001_0001_0002, 1'b0);
    total++;
    if (got[0] !== 16'h0001 || got[1] !== 16'h0004 || got[2] !== 16'h0004 || got[3] !== 16'h0005 || got_done !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_next_op got %h %h %h %h done=%b want 0001 0004 0004 0005 1",
               got[0], got[1], got[2], got[3], got_done);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
